arq_ctrl: RTL and testbench
===========================

# arq_ctrl

Stop-and-wait ARQ scheduler that sequences the OTN sender for one buffered frame at a time. It issues frame-start commands, waits for the receiver's ACK/NAK over the return path, and times out lost acknowledgements. It retransmits up to a retry limit, then releases or drops the frame. It sits between the sender's frame buffer and the OTN framer, replacing the manual retransmit-enable handshake.

## Interface
- TIMEOUT_CYCLES, 1024, cycles spent in WAIT_ACK before declaring a lost ACK; 2..2^CNT_W-1
- MAX_RETRIES, 3, retransmissions allowed per frame; 0..15
- CNT_W, 16, timeout timer width
- i_clk  in  1  system clock, all logic on rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_arq_en  in  1  1: wait for ACK; 0: fire-and-forget
- i_frame_req  in  1  frame buffer holds a frame ready to send (level)
- i_frame_done  in  1  one-cycle pulse, sender finished serialising frame
- i_ack_valid  in  1  one-cycle pulse, acknowledgement received
- i_ack_ok  in  1  qualifies i_ack_valid: 1=ACK (CRC good), 0=NAK
- o_frame_start  out  1  one-cycle pulse, start serialising buffered frame
- o_retrans  out  1  high with o_frame_start when the send is a retransmission
- o_frame_release  out  1  one-cycle pulse, buffer may discard frame
- o_frame_drop  out  1  one-cycle pulse with o_frame_release when retries are exhausted
- o_busy  out  1  high whenever state != IDLE
- o_retry_cnt  out  4  retransmissions issued for current frame
- o_state  out  3  current state encoding
- o_tx_count, o_retx_count, o_drop_count  out  16 each  statistics (see Configuration)

## Operation
- States: IDLE=0, SEND=1, WAIT_ACK=2, RETRY=3, DONE=4, DROP=5; values 6 and 7 go to IDLE.
- IDLE: if i_frame_req=1, go to SEND, clear retry_cnt and latch i_arq_en into arq_lat.
- SEND: on i_frame_done:
  - arq_lat=0: go to DONE.
  - arq_lat=1: go to WAIT_ACK with timer=0.
- SEND ignores i_frame_done in its first cycle (the o_frame_start cycle).
- WAIT_ACK:
  - Timer increments each cycle.
  - ACK (i_ack_valid & i_ack_ok): go to DONE.
  - NAK, or timer = TIMEOUT_CYCLES-1: retry_cnt = MAX_RETRIES goes to DROP; otherwise go to RETRY.
- RETRY: retry_cnt += 1, then go to SEND with o_retrans=1.
- DONE and DROP each last one cycle, then return to IDLE.
- Ack priority: a valid ACK or NAK in the same cycle as the timeout wins; the timeout is ignored.
- i_ack_valid outside WAIT_ACK (IDLE, SEND, RETRY, DONE, DROP) is stale and discarded.
- arq_lat is frozen for the whole frame, including retries; i_arq_en changes apply to the next frame only.
- retry_cnt saturates at 15, and never exceeds MAX_RETRIES by construction.

## Timing
- All outputs are registered; reset value 0 for every output, state=IDLE, timer=0, retry_cnt=0.
- o_frame_start and o_retrans: high exactly in the first cycle of SEND.
  - i_frame_req sampled high at edge k gives o_frame_start high during cycle k+1.
- Retransmit latency from NAK: NAK sampled at edge k → RETRY in cycle k+1 → o_frame_start with o_retrans=1 in cycle k+2.
- Timeout: fires after exactly TIMEOUT_CYCLES cycles in WAIT_ACK; first o_frame_start of the retry follows 2 cycles later.
- o_frame_release: high during the single DONE or DROP cycle.
- o_frame_drop: high only in DROP.
- The next frame can start in the cycle after DONE/DROP if i_frame_req is still high. The buffer must deassert i_frame_req by then if it has no new frame.
- Reset mid-operation: immediate return to IDLE; the in-flight frame is abandoned, with no release or drop pulse.

## Configuration
- ARQ_CTRL_STATS_EN defined:
  - o_tx_count increments on every o_frame_start.
  - o_retx_count increments on every o_frame_start with o_retrans=1.
  - o_drop_count increments on every o_frame_drop.
  - All three are 16-bit, saturate at 0xFFFF and are cleared by i_rst.
- Not defined: all three ports exist and are tied to 0; no counter logic is synthesised.

## Test plan
All scenarios use TIMEOUT_CYCLES=16 and MAX_RETRIES=2 unless stated.
- Clean ACK:
  - Stimulus: i_arq_en=1, i_frame_req at edge 0, i_frame_done at cycle 10, ACK at cycle 14.
  - Response: o_frame_start in cycle 1, o_frame_release in cycle 15, o_retry_cnt=0, o_frame_drop never asserted.
- NAK then ACK:
  - Stimulus: one NAK in WAIT_ACK, then ACK after the retransmission.
  - Response: second o_frame_start has o_retrans=1 two cycles after the NAK; release follows; o_retry_cnt=1; with STATS, tx=2 and retx=1.
- Lost ACKs:
  - Stimulus: no ACK ever.
  - Response: each WAIT_ACK lasts exactly 16 cycles; 3 starts total (1 original + 2 retries); then o_frame_release and o_frame_drop together; with STATS, drop_count=1.
- Collision: ACK arrives on the same cycle the timer hits 15 → DONE, no retransmit.
- ARQ off:
  - Stimulus: i_arq_en=0 at start, toggled to 1 mid-frame.
  - Response: release in the cycle after i_frame_done; WAIT_ACK never entered; a stray i_ack_valid is ignored.
- Reset: assert i_rst in WAIT_ACK → all outputs 0 asynchronously; no release pulse; next frame starts with retry_cnt=0.

Source files
------------

// File: rtl/arq_ctrl.sv
// Stop-and-wait ARQ scheduler: sends one buffered frame, waits for ACK/NAK or timeout, retries, then releases or drops it.
// Define ARQ_CTRL_STATS_EN to build the tx/retx/drop statistics counters; otherwise those ports are tied to zero.
module arq_ctrl #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_RETRIES    = 3,
  parameter int CNT_W          = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_arq_en,
  input  logic        i_frame_req,
  input  logic        i_frame_done,
  input  logic        i_ack_valid,
  input  logic        i_ack_ok,
  output logic        o_frame_start,
  output logic        o_retrans,
  output logic        o_frame_release,
  output logic        o_frame_drop,
  output logic        o_busy,
  output logic [3:0]  o_retry_cnt,
  output logic [2:0]  o_state,
  output logic [15:0] o_tx_count,
  output logic [15:0] o_retx_count,
  output logic [15:0] o_drop_count
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEND     = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_RETRY    = 3'd3,
    ST_DONE     = 3'd4,
    ST_DROP     = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] TIMER_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRIES);

  state_t           state;
  logic [CNT_W-1:0] timer;
  logic [3:0]       retry_cnt;
  logic             arq_lat;
  logic             frame_start_q;
  logic             retrans_q;
  logic             release_q;
  logic             drop_q;
  logic             busy_q;

  // frame_start_q doubles as the "first SEND cycle" marker, so a done pulse
  // coinciding with the start command is never mistaken for completion.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= ST_IDLE;
      timer         <= '0;
      retry_cnt     <= '0;
      arq_lat       <= 1'b0;
      frame_start_q <= 1'b0;
      retrans_q     <= 1'b0;
      release_q     <= 1'b0;
      drop_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      retrans_q     <= 1'b0;
      release_q     <= 1'b0;
      drop_q        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_frame_req) begin
            state         <= ST_SEND;
            retry_cnt     <= '0;
            arq_lat       <= i_arq_en;
            frame_start_q <= 1'b1;
            busy_q        <= 1'b1;
          end
        end
        ST_SEND: begin
          if (!frame_start_q && i_frame_done) begin
            if (arq_lat) begin
              state <= ST_WAIT_ACK;
              timer <= '0;
            end else begin
              state     <= ST_DONE;
              release_q <= 1'b1;
            end
          end
        end
        // A real ACK/NAK outranks a timeout landing on the same cycle.
        ST_WAIT_ACK: begin
          timer <= timer + 1'b1;
          if (i_ack_valid && i_ack_ok) begin
            state     <= ST_DONE;
            release_q <= 1'b1;
          end else if (i_ack_valid || (timer == TIMER_LAST)) begin
            if (retry_cnt >= RETRY_LIMIT) begin
              state     <= ST_DROP;
              release_q <= 1'b1;
              drop_q    <= 1'b1;
            end else begin
              state <= ST_RETRY;
            end
          end
        end
        ST_RETRY: begin
          if (retry_cnt != 4'hF) begin
            retry_cnt <= retry_cnt + 4'd1;
          end
          state         <= ST_SEND;
          frame_start_q <= 1'b1;
          retrans_q     <= 1'b1;
        end
        ST_DONE, ST_DROP: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_frame_start   = frame_start_q;
  assign o_retrans       = retrans_q;
  assign o_frame_release = release_q;
  assign o_frame_drop    = drop_q;
  assign o_busy          = busy_q;
  assign o_retry_cnt     = retry_cnt;
  assign o_state         = state;

`ifdef ARQ_CTRL_STATS_EN
  logic [15:0] tx_count;
  logic [15:0] retx_count;
  logic [15:0] drop_count;

  // Counters follow the registered pulses, so they update one cycle after each event.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tx_count   <= '0;
      retx_count <= '0;
      drop_count <= '0;
    end else begin
      if (frame_start_q && (tx_count != 16'hFFFF)) begin
        tx_count <= tx_count + 16'd1;
      end
      if (frame_start_q && retrans_q && (retx_count != 16'hFFFF)) begin
        retx_count <= retx_count + 16'd1;
      end
      if (drop_q && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

  assign o_tx_count   = tx_count;
  assign o_retx_count = retx_count;
  assign o_drop_count = drop_count;
`else
  assign o_tx_count   = '0;
  assign o_retx_count = '0;
  assign o_drop_count = '0;
`endif

endmodule

// File: tb/tb_arq_ctrl.sv
// Bench for arq_ctrl: a frame-level thread model predicts every output each cycle,
// and directed scenarios add hand-computed cycle-exact checks on top of it.
module tb_arq_ctrl;

  localparam int TIMEOUT = 16;
  localparam int MAXR    = 2;
`ifdef ARQ_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        i_clk        = 1'b0;
  logic        i_rst        = 1'b1;
  logic        i_arq_en     = 1'b0;
  logic        i_frame_req  = 1'b0;
  logic        i_frame_done = 1'b0;
  logic        i_ack_valid  = 1'b0;
  logic        i_ack_ok     = 1'b0;
  logic        o_frame_start;
  logic        o_retrans;
  logic        o_frame_release;
  logic        o_frame_drop;
  logic        o_busy;
  logic [3:0]  o_retry_cnt;
  logic [2:0]  o_state;
  logic [15:0] o_tx_count;
  logic [15:0] o_retx_count;
  logic [15:0] o_drop_count;

  arq_ctrl #(.TIMEOUT_CYCLES(TIMEOUT), .MAX_RETRIES(MAXR), .CNT_W(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_arq_en(i_arq_en), .i_frame_req(i_frame_req),
    .i_frame_done(i_frame_done), .i_ack_valid(i_ack_valid), .i_ack_ok(i_ack_ok),
    .o_frame_start(o_frame_start), .o_retrans(o_retrans), .o_frame_release(o_frame_release),
    .o_frame_drop(o_frame_drop), .o_busy(o_busy), .o_retry_cnt(o_retry_cnt), .o_state(o_state),
    .o_tx_count(o_tx_count), .o_retx_count(o_retx_count), .o_drop_count(o_drop_count)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic checkOutput(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model expectations for the current cycle
  int exp_state, exp_retry;
  bit exp_start, exp_retrans, exp_release, exp_drop;
  int m_retries, m_tx, m_retx, m_drops;
  bit m_lat;

  task automatic show(int st, bit start, bit rt, bit rel, bit drp);
    exp_state   = st;
    exp_start   = start;
    exp_retrans = rt;
    exp_release = rel;
    exp_drop    = drp;
    exp_retry   = m_retries;
  endtask

  task automatic tick();
    @(posedge i_clk);
    if (exp_start) begin
      if (m_tx < 65535) m_tx++;
      if (exp_retrans && m_retx < 65535) m_retx++;
    end
    if (exp_drop && m_drops < 65535) m_drops++;
  endtask

  task automatic model_zero();
    m_retries = 0;
    m_tx = 0;
    m_retx = 0;
    m_drops = 0;
    show(0, 0, 0, 0, 0);
  endtask

  task automatic model_run();
    int  t;
    bit  acked;
    forever begin
      show(0, 0, 0, 0, 0);
      tick();
      if (!i_frame_req) continue;
      m_lat = i_arq_en;
      m_retries = 0;
      forever begin
        show(1, 1, m_retries > 0, 0, 0);
        tick();
        do begin
          show(1, 0, 0, 0, 0);
          tick();
        end while (!i_frame_done);
        if (!m_lat) begin
          show(4, 0, 0, 1, 0);
          tick();
          break;
        end
        t = 0;
        acked = 1'b0;
        forever begin
          show(2, 0, 0, 0, 0);
          tick();
          if (i_ack_valid && i_ack_ok) begin
            acked = 1'b1;
            break;
          end
          if (i_ack_valid || t == TIMEOUT - 1) break;
          t++;
        end
        if (acked) begin
          show(4, 0, 0, 1, 0);
          tick();
          break;
        end
        if (m_retries == MAXR) begin
          show(5, 0, 0, 1, 1);
          tick();
          break;
        end
        show(3, 0, 0, 0, 0);
        tick();
        if (m_retries < 15) m_retries++;
      end
    end
  endtask

  // Reset kills the in-flight frame thread and restarts the model from idle.
  initial begin : model_proc
    forever begin
      if (i_rst) begin
        model_zero();
        @(negedge i_rst);
      end
      fork
        model_run();
        @(posedge i_rst);
      join_any
      disable fork;
    end
  end

  always @(negedge i_clk) begin
    checkOutput("state", int'(o_state), exp_state);
    checkOutput("busy", int'(o_busy), int'(exp_state != 0));
    checkOutput("frame_start", int'(o_frame_start), int'(exp_start));
    checkOutput("retrans", int'(o_retrans), int'(exp_retrans));
    checkOutput("release", int'(o_frame_release), int'(exp_release));
    checkOutput("drop", int'(o_frame_drop), int'(exp_drop));
    checkOutput("retry_cnt", int'(o_retry_cnt), exp_retry);
    checkOutput("tx_count", int'(o_tx_count), STATS ? m_tx : 0);
    checkOutput("retx_count", int'(o_retx_count), STATS ? m_retx : 0);
    checkOutput("drop_count", int'(o_drop_count), STATS ? m_drops : 0);
  end

  int fc;

  task automatic adv(int n);
    while (fc < n) begin
      @(posedge i_clk);
      #1;
      fc++;
    end
  endtask

  task automatic applyStimulus(int at, bit done, bit av, bit ok);
    adv(at);
    i_frame_done = done;
    i_ack_valid  = av;
    i_ack_ok     = ok;
    adv(at + 1);
    i_frame_done = 1'b0;
    i_ack_valid  = 1'b0;
    i_ack_ok     = 1'b0;
  endtask

  task automatic start_frame(bit arq);
    fc = 0;
    i_arq_en    = arq;
    i_frame_req = 1'b1;
    adv(1);
    i_frame_req = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    #2;
    checkOutput("reset state", int'(o_state), 0);
    checkOutput("reset busy", int'(o_busy), 0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    fc = 0;
    adv(3);

    $display("[TB] clean ACK");
    start_frame(1'b1);
    checkOutput("clean start c1", int'(o_frame_start), 1);
    checkOutput("clean retrans c1", int'(o_retrans), 0);
    applyStimulus(10, 1, 0, 0);
    applyStimulus(14, 0, 1, 1);
    checkOutput("clean release c15", int'(o_frame_release), 1);
    checkOutput("clean drop c15", int'(o_frame_drop), 0);
    checkOutput("clean retry c15", int'(o_retry_cnt), 0);
    adv(17);

    $display("[TB] NAK then ACK");
    start_frame(1'b1);
    applyStimulus(3, 1, 0, 0);
    applyStimulus(6, 0, 1, 0);
    checkOutput("nak retry state c7", int'(o_state), 3);
    adv(8);
    checkOutput("nak restart c8", int'(o_frame_start), 1);
    checkOutput("nak retrans c8", int'(o_retrans), 1);
    checkOutput("nak retry_cnt c8", int'(o_retry_cnt), 1);
    applyStimulus(10, 1, 0, 0);
    applyStimulus(12, 0, 1, 1);
    checkOutput("nak release c13", int'(o_frame_release), 1);
    checkOutput("nak final retry c13", int'(o_retry_cnt), 1);
    adv(15);

    $display("[TB] lost ACKs");
    start_frame(1'b1);
    applyStimulus(2, 1, 0, 0);
    adv(18);
    checkOutput("lost wait last c18", int'(o_state), 2);
    adv(19);
    checkOutput("lost retry c19", int'(o_state), 3);
    adv(20);
    checkOutput("lost restart1 c20", int'(o_frame_start), 1);
    checkOutput("lost retrans1 c20", int'(o_retrans), 1);
    applyStimulus(21, 1, 0, 0);
    adv(39);
    checkOutput("lost restart2 c39", int'(o_frame_start), 1);
    checkOutput("lost retry2 c39", int'(o_retry_cnt), 2);
    applyStimulus(40, 1, 0, 0);
    adv(57);
    checkOutput("lost release c57", int'(o_frame_release), 1);
    checkOutput("lost drop c57", int'(o_frame_drop), 1);
    checkOutput("lost state c57", int'(o_state), 5);
    adv(59);

    $display("[TB] ACK/timeout collision");
    start_frame(1'b1);
    applyStimulus(2, 1, 0, 0);
    applyStimulus(18, 0, 1, 1);
    checkOutput("collide state c19", int'(o_state), 4);
    checkOutput("collide drop c19", int'(o_frame_drop), 0);
    adv(20);
    checkOutput("collide no restart c20", int'(o_frame_start), 0);
    adv(22);

    $display("[TB] ARQ off");
    start_frame(1'b0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("arqoff ignore first done c2", int'(o_state), 1);
    applyStimulus(2, 0, 1, 1);
    i_arq_en = 1'b1;
    applyStimulus(5, 1, 0, 0);
    checkOutput("arqoff release c6", int'(o_frame_release), 1);
    checkOutput("arqoff state c6", int'(o_state), 4);
    applyStimulus(7, 0, 1, 0);
    adv(9);

    $display("[TB] reset in WAIT_ACK");
    start_frame(1'b1);
    applyStimulus(2, 1, 0, 0);
    applyStimulus(4, 0, 1, 0);
    applyStimulus(7, 1, 0, 0);
    adv(10);
    checkOutput("rst pre retry c10", int'(o_retry_cnt), 1);
    #2;
    i_rst = 1'b1;
    #1;
    checkOutput("rst async state", int'(o_state), 0);
    checkOutput("rst async busy", int'(o_busy), 0);
    checkOutput("rst async retry", int'(o_retry_cnt), 0);
    adv(12);
    i_rst = 1'b0;
    adv(14);
    checkOutput("rst no release", int'(o_frame_release), 0);
    start_frame(1'b1);
    checkOutput("rst next start", int'(o_frame_start), 1);
    checkOutput("rst next retry", int'(o_retry_cnt), 0);
    applyStimulus(2, 1, 0, 0);
    applyStimulus(4, 0, 1, 1);
    checkOutput("rst next release c5", int'(o_frame_release), 1);
    adv(7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
